// File: rtl/dram_load_store_unit.sv
// Multi-cycle data-memory access unit: execute-stage request to DRAM req/ack.
// Define LSU_LOAD_SEXT_EN to sign-extend byte/half loads (default zero-fill).
module dram_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        lsu_clk,
  input  logic        lsu_rst,
  input  logic        lsu_start,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] rdo,
  output logic        dram_req,
  output logic        dram_we,
  output logic [3:0]  dram_be,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  input  logic        dram_ack,
  input  logic [31:0] dram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [1:0]  k_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdo_q;
  logic [15:0] cnt_q;

  logic        misal;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic        timeout;
  logic [15:0] sh;
  logic [23:0] fill8;
  logic [15:0] fill16;
  logic [31:0] ld_c;

  always_comb begin
    misal = 1'b0;
    be_c  = 4'b0000;
    wd_c  = lsu_wdata;
    unique case (lsu_size)
      2'b00: begin
        be_c = 4'b0001 << lsu_addr[1:0];
        wd_c = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        misal = lsu_addr[0];
        be_c  = lsu_addr[1] ? 4'b1100 : 4'b0011;
        wd_c  = {2{lsu_wdata[15:0]}};
      end
      2'b10: begin
        misal = |lsu_addr[1:0];
        be_c  = 4'b1111;
      end
      default: misal = 1'b1;
    endcase
  end

  assign timeout = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Only the low half of the shifted word is ever used for sub-word loads.
  assign sh = 16'(dram_rdata >> {k_q, 3'b000});

`ifdef LSU_LOAD_SEXT_EN
  assign fill8  = {24{sh[7]}};
  assign fill16 = {16{sh[15]}};
`else
  assign fill8  = '0;
  assign fill16 = '0;
`endif

  always_comb begin
    unique case (size_q)
      2'b00:   ld_c = {fill8, sh[7:0]};
      2'b01:   ld_c = {fill16, sh};
      default: ld_c = dram_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (lsu_start) state_d = misal ? S_RESP : S_REQ;
      S_REQ:  if (dram_ack || timeout) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      k_q     <= 2'b00;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdo_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
      if (lsu_start) begin
        we_q    <= lsu_we;
        err_q   <= misal;
        size_q  <= lsu_size;
        k_q     <= lsu_addr[1:0];
        be_q    <= be_c;
        addr_q  <= {lsu_addr[31:2], 2'b00};
        wdata_q <= wd_c;
      end
    end else if (state_q == S_REQ) begin
      if (dram_ack) begin
        err_q <= 1'b0;
        if (!we_q) rdo_q <= ld_c;
      end else if (timeout) begin
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign lsu_busy   = (state_q == S_REQ);
  assign lsu_done   = (state_q == S_RESP);
  assign lsu_err    = lsu_done & err_q;
  assign rdo        = rdo_q;
  assign dram_req   = (state_q == S_REQ);
  assign dram_we    = dram_req & we_q;
  assign dram_be    = dram_req ? be_q : 4'b0000;
  assign dram_addr  = addr_q;
  assign dram_wdata = wdata_q;

endmodule

// File: tb/tb_dram_load_store_unit.sv
// Bench for dram_load_store_unit: directed table, reset/ignore sequences,
// and random accesses against a lane-level reference model.
module tb_dram_load_store_unit;

  localparam int TO = 4;

`ifdef LSU_LOAD_SEXT_EN
  localparam logic [31:0] RD_B = 32'hFFFFFF80;
  localparam logic [31:0] RD_H = 32'hFFFF8001;
`else
  localparam logic [31:0] RD_B = 32'h00000080;
  localparam logic [31:0] RD_H = 32'h00008001;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] rdo;
  logic        dram_req, dram_we;
  logic [3:0]  dram_be;
  logic [31:0] dram_addr, dram_wdata;
  logic        dram_ack = 1'b0;
  logic [31:0] dram_rdata = '0;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_rdo = '0;

  always #5 clk = ~clk;

  dram_load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .lsu_clk(clk),
    .lsu_rst(rst),
    .lsu_start(start),
    .lsu_we(we),
    .lsu_size(size),
    .lsu_addr(addr),
    .lsu_wdata(wdata),
    .lsu_busy(busy),
    .lsu_done(done),
    .lsu_err(err),
    .rdo(rdo),
    .dram_req(dram_req),
    .dram_we(dram_we),
    .dram_be(dram_be),
    .dram_addr(dram_addr),
    .dram_wdata(dram_wdata),
    .dram_ack(dram_ack),
    .dram_rdata(dram_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackdly;
    bit          poke;
    logic        err;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] rdo;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [1:0] sz, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [7:0] lane [4];
    int unsigned v;
    int k;
    for (int i = 0; i < 4; i++) lane[i] = rd[8*i +: 8];
    k = int'(a[1:0]);
    if (sz == 2'b10) return rd;
    if (sz == 2'b00) begin
      v = lane[k];
`ifdef LSU_LOAD_SEXT_EN
      if (v >= 128) v = v + 32'hFFFFFF00;
`endif
    end else begin
      v = lane[k] + 256 * lane[k+1];
`ifdef LSU_LOAD_SEXT_EN
      if (v >= 32768) v = v + 32'hFFFF0000;
`endif
    end
    return v;
  endfunction

  task automatic run_acc(input vec_t v);
    int cyc;
    int n;
    start = 1'b1;
    we    = v.we;
    size  = v.size;
    addr  = v.addr;
    wdata = v.wdata;
    dram_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    n = 0;
    while (cyc < v.lat && n < 64) begin
      chk("req_hi", dram_req, 1);
      chk("busy_hi", busy, 1);
      chk("done_early", done, 0);
      chk("be", dram_be, v.be);
      chk("daddr", dram_addr, {v.addr[31:2], 2'b00});
      chk("dwe", dram_we, v.we);
      chk("dwdata", dram_wdata, v.ewd);
      if (v.poke && n == 1) start = 1'b1;
      if (n == v.ackdly) begin
        dram_ack = 1'b1;
        dram_rdata = v.rdata;
      end
      @(negedge clk);
      start = 1'b0;
      dram_ack = 1'b0;
      dram_rdata = $urandom;
      cyc++;
      n++;
    end
    chk("done", done, 1);
    chk("err", err, v.err);
    chk("rdo", rdo, v.rdo);
    chk("req_lo", dram_req, 0);
    chk("busy_lo", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_req", dram_req, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    vec_t v;
    bit mis;
    int k;

    tbl[0] = '{1'b0, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0,
               1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 4};
    tbl[1] = '{1'b0, 2'b00, 32'h203, 32'h0, 32'h80112233, 0, 1'b0,
               1'b0, 4'b1000, 32'h0, RD_B, 2};
    tbl[2] = '{1'b1, 2'b01, 32'h302, 32'h0000ABCD, 32'h55555555, 0, 1'b0,
               1'b0, 4'b1100, 32'hABCDABCD, RD_B, 2};
    tbl[3] = '{1'b0, 2'b10, 32'h101, 32'h0, 32'h0, -1, 1'b0,
               1'b1, 4'b0000, 32'h0, RD_B, 1};
    tbl[4] = '{1'b0, 2'b11, 32'h100, 32'h0, 32'h0, -1, 1'b0,
               1'b1, 4'b0000, 32'h0, RD_B, 1};
    tbl[5] = '{1'b0, 2'b10, 32'h400, 32'h0, 32'h0, -1, 1'b1,
               1'b1, 4'b1111, 32'h0, RD_B, TO + 1};
    tbl[6] = '{1'b0, 2'b01, 32'h302, 32'h0, 32'h80017FFF, 1, 1'b0,
               1'b0, 4'b1100, 32'h0, RD_H, 3};
    tbl[7] = '{1'b1, 2'b00, 32'h501, 32'h123456A5, 32'h0, 0, 1'b0,
               1'b0, 4'b0010, 32'hA5A5A5A5, RD_H, 2};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", dram_req, 0);
    chk("rst_we", dram_we, 0);
    chk("rst_be", dram_be, 0);
    chk("rst_rdo", rdo, 0);

    for (int i = 0; i < 8; i++) run_acc(tbl[i]);

    // Reset mid-request, then a stale ack must be ignored.
    start = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h600;
    @(negedge clk);
    start = 1'b0;
    chk("mid_req", dram_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_req", dram_req, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_rdo", rdo, 0);
    dram_ack = 1'b1;
    dram_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dram_ack = 1'b0;
    chk("late_done", done, 0);
    chk("late_rdo", rdo, 0);
    chk("late_busy", busy, 0);
    @(negedge clk);
    chk("late_done2", done, 0);
    model_rdo = '0;

    for (int i = 0; i < 60; i++) begin
      v.we    = 1'($urandom % 2);
      v.size  = 2'($urandom % 4);
      v.addr  = $urandom;
      if ($urandom % 2 == 1) v.addr[1:0] = (v.size == 2'b01) ? {v.addr[1], 1'b0} : 2'b00;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.ackdly = $urandom_range(0, 5);
      v.poke = 1'b0;
      k = int'(v.addr[1:0]);
      mis = (v.size == 2'b11) || (v.size == 2'b01 && k % 2 != 0) || (v.size == 2'b10 && k != 0);
      v.err = mis || v.ackdly >= TO;
      case (v.size)
        2'b00: begin v.be = 4'(1 << k); v.ewd = v.wdata[7:0] * 32'h01010101; end
        2'b01: begin v.be = (k >= 2) ? 4'd12 : 4'd3; v.ewd = v.wdata[15:0] * 32'h00010001; end
        default: begin v.be = 4'd15; v.ewd = v.wdata; end
      endcase
      if (mis) v.lat = 1;
      else if (v.ackdly >= TO) v.lat = TO + 1;
      else v.lat = v.ackdly + 2;
      if (!v.err && !v.we) model_rdo = load_val(v.size, v.addr, v.rdata);
      v.rdo = model_rdo;
      run_acc(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
